// File: rtl/hdu_scoreboard.sv
// Long-instruction scoreboard: tracks in-flight destination registers, flags RAW/WAW/full stalls.
// Optional per-entry watchdog is enabled by defining HDU_TIMEOUT_EN.
module hdu_scoreboard #(
   parameter int DEPTH          = 8,
   parameter int ID_W           = $clog2(DEPTH),
   parameter int NUM_COMMIT     = 2,
   parameter int REG_ADDR_W     = 5,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       inst_valid_i,
   input  logic [REG_ADDR_W-1:0]      rd_addr_i,
   input  logic [REG_ADDR_W-1:0]      rs1_addr_i,
   input  logic [REG_ADDR_W-1:0]      rs2_addr_i,
   input  logic                       rd_we_i,
   input  logic [NUM_COMMIT-1:0]      commit_valid_i,
   input  logic [NUM_COMMIT*ID_W-1:0] commit_id_i,
   input  logic                       flush_i,
   output logic                       stall_o,
   output logic                       alloc_valid_o,
   output logic [ID_W-1:0]            alloc_id_o,
   output logic                       busy_o,
   output logic [ID_W:0]              occupancy_o,
   output logic                       timeout_o,
   output logic [ID_W-1:0]            timeout_id_o
);

   function automatic logic [ID_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ID_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt = cnt + (ID_W+1)'(v[i]);
      return cnt;
   endfunction

   logic [DEPTH-1:0]      valid_r;
   logic [DEPTH-1:0]      rd_we_r;
   logic [REG_ADDR_W-1:0] rd_addr_r [DEPTH];
   logic [ID_W:0]         occupancy_r;
   logic                  busy_r;

   logic [DEPTH-1:0]      committing_s;
   logic [DEPTH-1:0]      live_s;
   logic [DEPTH-1:0]      valid_nxt_s;
   logic [ID_W-1:0]       free_id_s;
   logic                  raw_s;
   logic                  waw_s;
   logic                  full_s;
   logic                  stall_s;
   logic                  alloc_s;
   logic                  new_we_s;

   // Hazard, free-slot search and next-valid computation
   always_comb begin
      committing_s = '0;
      raw_s        = 1'b0;
      waw_s        = 1'b0;
      free_id_s    = '0;
      new_we_s     = rd_we_i && (rd_addr_i != '0);
      for (int i = 0; i < DEPTH; i++) begin
         for (int k = 0; k < NUM_COMMIT; k++) begin
            committing_s[i] = committing_s[i] |
               (commit_valid_i[k] && (commit_id_i[k*ID_W +: ID_W] == ID_W'(i)));
         end
      end
      live_s = valid_r & ~committing_s;
      for (int i = 0; i < DEPTH; i++) begin
         raw_s = raw_s | (live_s[i] && rd_we_r[i] &&
                 (((rd_addr_r[i] == rs1_addr_i) && (rs1_addr_i != '0)) ||
                  ((rd_addr_r[i] == rs2_addr_i) && (rs2_addr_i != '0))));
         waw_s = waw_s | (new_we_s && live_s[i] && rd_we_r[i] && (rd_addr_r[i] == rd_addr_i));
      end
      // Descending scan leaves the lowest non-live index
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!live_s[i]) free_id_s = ID_W'(i);
         else            free_id_s = free_id_s;
      end
      full_s  = &live_s;
      stall_s = inst_valid_i && !flush_i && (raw_s || waw_s || full_s);
      alloc_s = inst_valid_i && !flush_i && !stall_s;
      if (flush_i) valid_nxt_s = '0;
      else if (alloc_s) valid_nxt_s = live_s | (DEPTH'(1) << free_id_s);
      else valid_nxt_s = live_s;
   end

   assign stall_o       = stall_s;
   assign alloc_valid_o = alloc_s;
   assign alloc_id_o    = alloc_s ? free_id_s : '0;
   assign busy_o        = busy_r;
   assign occupancy_o   = occupancy_r;

   // Entry table and registered status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r     <= '0;
         rd_we_r     <= '0;
         occupancy_r <= '0;
         busy_r      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) rd_addr_r[i] <= '0;
      end else begin
         valid_r     <= valid_nxt_s;
         occupancy_r <= popcount(valid_nxt_s);
         busy_r      <= |valid_nxt_s;
         if (alloc_s) begin
            rd_we_r[free_id_s]   <= new_we_s;
            rd_addr_r[free_id_s] <= rd_addr_i;
         end
      end
   end

`ifdef HDU_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

   logic [AGE_W-1:0] age_r     [DEPTH];
   logic [AGE_W-1:0] age_nxt_s [DEPTH];
   logic [DEPTH-1:0] pending_r;
   logic [DEPTH-1:0] pending_nxt_s;
   logic             rep_valid_s;
   logic [ID_W-1:0]  rep_id_s;
   logic             timeout_r;
   logic [ID_W-1:0]  timeout_id_r;

   // Age counters, sticky pending flags and lowest-pending selection
   always_comb begin
      rep_valid_s = |pending_r;
      rep_id_s    = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (pending_r[i]) rep_id_s = ID_W'(i);
         else              rep_id_s = rep_id_s;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (flush_i || committing_s[i] || (alloc_s && (free_id_s == ID_W'(i)))) begin
            age_nxt_s[i]     = '0;
            pending_nxt_s[i] = 1'b0;
         end else if (valid_r[i]) begin
            age_nxt_s[i]     = (age_r[i] == AGE_MAX) ? age_r[i] : age_r[i] + AGE_W'(1);
            pending_nxt_s[i] = pending_r[i] | (age_r[i] == (AGE_MAX - AGE_W'(1)));
         end else begin
            age_nxt_s[i]     = '0;
            pending_nxt_s[i] = 1'b0;
         end
      end
      if (rep_valid_s) pending_nxt_s[rep_id_s] = 1'b0;
      else             pending_nxt_s = pending_nxt_s;
   end

   // Watchdog state and one-cycle report pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r    <= '0;
         timeout_r    <= 1'b0;
         timeout_id_r <= '0;
         for (int i = 0; i < DEPTH; i++) age_r[i] <= '0;
      end else begin
         pending_r    <= pending_nxt_s;
         timeout_r    <= rep_valid_s;
         timeout_id_r <= rep_id_s;
         for (int i = 0; i < DEPTH; i++) age_r[i] <= age_nxt_s[i];
      end
   end

   assign timeout_o    = timeout_r;
   assign timeout_id_o = timeout_id_r;
`else
   assign timeout_o    = 1'b0;
   assign timeout_id_o = '0;
`endif

endmodule
